// File: rtl/conv_rapida.sv
// Winograd F(4x4,3x3) single-tile convolution engine.
// 5x5 tile in, 6x6 transformed kernel in, 3x3 result out.

package packConv;
   localparam int NBITS = 32;
   typedef logic signed [NBITS-1:0] param36 [0:35];
   typedef logic signed [NBITS-1:0] param25 [0:24];
   typedef logic signed [NBITS-1:0] param9  [0:8];
endpackage

module conv_rapida
   import packConv::*;
#(
   parameter int QUANT = 8
) (
   input  logic   clk,
   input  logic   reset,
   input  logic   start,
   input  param25 inputMAP,
   input  param36 weights,
   output param9  outputMAP,
   output logic   data_valid
);

   localparam int VW = NBITS + 8;
   localparam int MW = 2 * NBITS + 8;
   localparam int YW = 2 * NBITS + 18;

   typedef enum logic [2:0] {
      IDLE, LOAD, XFORM_IN, MULT, XFORM_OUT
   } state_t;

   state_t state;
   logic   start_q;
   logic   trig;

   logic signed [NBITS-1:0] d_r [0:5][0:5];
   logic signed [NBITS-1:0] u_r [0:5][0:5];
   logic signed [VW-1:0]    v_r [0:5][0:5];
   logic signed [MW-1:0]    m_r [0:5][0:5];

   logic signed [VW-1:0] t  [0:5][0:5];
   logic signed [VW-1:0] vn [0:5][0:5];
   logic signed [YW-1:0] mx [0:5][0:5];
   logic signed [YW-1:0] y1 [0:2][0:5];
   logic signed [YW-1:0] yf [0:2][0:2];

   // One row of B^T applied to a 6-vector, shift/add only.
   function automatic logic signed [VW-1:0] bt_row(
      input logic [2:0] r,
      input logic signed [VW-1:0] x0, x1, x2, x3, x4, x5
   );
      logic signed [VW-1:0] s;
      case (r)
         3'd0: s = (x0 <<< 2) - (x2 <<< 2) - x2 + x4;
         3'd1: s = x3 + x4 - (x1 <<< 2) - (x2 <<< 2);
         3'd2: s = (x1 <<< 2) - (x2 <<< 2) - x3 + x4;
         3'd3: s = (x3 <<< 1) - (x1 <<< 1) - x2 + x4;
         3'd4: s = (x1 <<< 1) - (x3 <<< 1) - x2 + x4;
         3'd5: s = (x1 <<< 2) - (x3 <<< 2) - x3 + x5;
         default: s = '0;
      endcase
      return s;
   endfunction

   // One row of A^T applied to a 6-vector, shift/add only.
   function automatic logic signed [YW-1:0] at_row(
      input logic [1:0] r,
      input logic signed [YW-1:0] x0, x1, x2, x3, x4, x5
   );
      logic signed [YW-1:0] s;
      case (r)
         2'd0: s = x0 + x1 + x2 + x3 + x4;
         2'd1: s = x1 - x2 + (x3 <<< 1) - (x4 <<< 1);
         2'd2: s = x1 + x2 + (x3 <<< 2) + (x4 <<< 2);
         default: s = x1 - x2 + (x3 <<< 3) - (x4 <<< 3) + x5;
      endcase
      return s;
   endfunction

   assign trig = start && !start_q;

   // Input transform V = B^T d B: columns first, then rows.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            t[i][j] = bt_row(3'(i),
               VW'(d_r[0][j]), VW'(d_r[1][j]), VW'(d_r[2][j]),
               VW'(d_r[3][j]), VW'(d_r[4][j]), VW'(d_r[5][j]));
         end
      end
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            vn[i][j] = bt_row(3'(j),
               t[i][0], t[i][1], t[i][2],
               t[i][3], t[i][4], t[i][5]);
         end
      end
   end

   // Output transform, only the 3x3 corner that survives.
   always_comb begin
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 6; j++) begin
            mx[i][j] = YW'(m_r[i][j]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 6; j++) begin
            y1[i][j] = at_row(2'(i),
               mx[0][j], mx[1][j], mx[2][j],
               mx[3][j], mx[4][j], mx[5][j]);
         end
      end
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            yf[i][j] = at_row(2'(j),
               y1[i][0], y1[i][1], y1[i][2],
               y1[i][3], y1[i][4], y1[i][5]);
         end
      end
   end

   // Control FSM, edge detector and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         data_valid <= 1'b0;
         for (int i = 0; i < 9; i++) outputMAP[i] <= '0;
      end else begin
         start_q    <= start;
         data_valid <= 1'b0;
         unique case (state)
            IDLE:     if (trig) state <= LOAD;
            LOAD:     state <= XFORM_IN;
            XFORM_IN: state <= MULT;
            MULT:     state <= XFORM_OUT;
            XFORM_OUT: begin
               for (int r = 0; r < 3; r++) begin
                  for (int c = 0; c < 3; c++) begin
                     outputMAP[3*r+c] <= NBITS'(yf[r][c] >>> QUANT);
                  end
               end
               data_valid <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Datapath pipeline registers; an aborted result never reaches the outputs.
   always_ff @(posedge clk) begin
      if (state == IDLE && trig) begin
         for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
               d_r[r][c] <= (r < 5 && c < 5) ? inputMAP[5*r+c] : '0;
               u_r[r][c] <= weights[6*r+c];
            end
         end
      end
      if (state == XFORM_IN) begin
         for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) v_r[i][j] <= vn[i][j];
         end
      end
      if (state == MULT) begin
         for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
               m_r[i][j] <= MW'(u_r[i][j]) * MW'(v_r[i][j]);
            end
         end
      end
   end

endmodule

// File: tb/tb_conv_rapida.sv
// Testbench for conv_rapida: directed cases plus random tiles
// checked against a plain matrix-product reference model.

module tb_conv_rapida;
   import packConv::*;

   localparam int QUANT = 8;

   logic   clk = 1'b0;
   logic   reset;
   logic   start;
   param25 in_map;
   param36 wts;
   param9  out_map;
   logic   dv;

   logic signed [31:0] exp_map [9];
   int npass = 0;
   int ntotal = 0;

   int BT [6][6] = '{
      '{4, 0, -5, 0, 1, 0},
      '{0, -4, -4, 1, 1, 0},
      '{0, 4, -4, -1, 1, 0},
      '{0, -2, -1, 2, 1, 0},
      '{0, 2, -1, -2, 1, 0},
      '{0, 4, 0, -5, 0, 1}
   };
   int AT [4][6] = '{
      '{1, 1, 1, 1, 1, 0},
      '{0, 1, -1, 2, -2, 0},
      '{0, 1, 1, 4, 4, 0},
      '{0, 1, -1, 8, -8, 1}
   };

   conv_rapida #(.QUANT(QUANT)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .inputMAP(in_map),
      .weights(wts),
      .outputMAP(out_map),
      .data_valid(dv)
   );

   always #5 clk = ~clk;

   // Reference: Y = A^T (U .* (B^T d B)) A, floor-shift, truncate.
   function automatic void model();
      longint d [6][6];
      longint v [6][6];
      longint m [6][6];
      longint y [4][4];
      longint acc;
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 6; c++)
            d[r][c] = (r < 5 && c < 5) ? longint'(in_map[5*r+c]) : 0;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++)
               for (int l = 0; l < 6; l++)
                  acc += BT[i][k] * d[k][l] * BT[j][l];
            v[i][j] = acc;
            m[i][j] = longint'(wts[6*i+j]) * acc;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++)
               for (int l = 0; l < 6; l++)
                  acc += AT[i][k] * m[k][l] * AT[j][l];
            y[i][j] = acc;
         end
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 3; c++)
            exp_map[3*r+c] = 32'(y[r][c] >>> QUANT);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise start for 'hold' cycles; record latency and pulse count.
   task automatic run(input int hold, output int lat, output int pulses);
      lat = -1;
      pulses = 0;
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == hold) start = 1'b0;
         if (dv) begin
            pulses++;
            if (lat < 0) lat = c - 1;
         end
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      int pulses;
      reset = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 25; i++) in_map[i] = '0;
      for (int i = 0; i < 36; i++) wts[i] = '0;
      repeat (3) tick();
      reset = 1'b0;
      for (int i = 0; i < 9; i++) begin
         ntotal++;
         if (out_map[i] !== 32'sd0) begin
            $display("FAIL reset_out[%0d]: got %0d want 0", i, out_map[i]);
         end else npass++;
      end
      ntotal++;
      if (dv !== 1'b0) $display("FAIL reset_dv: got %b want 0", dv);
      else npass++;
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (dv) pulses++;
      end
      ntotal++;
      if (pulses != 0) $display("FAIL idle_dv: got %0d want 0", pulses);
      else npass++;
   endtask

   task automatic test_impulse();
      int wv [5] = '{256, 256, 128, 1, 1};
      int dx [5] = '{1, -3, 1, -1, 1};
      int ex [5] = '{16, -48, 8, -1, 0};
      int hl [5] = '{5, 1, 1, 1, 1};
      int lat, pulses;
      for (int t = 0; t < 5; t++) begin
         for (int i = 0; i < 36; i++) wts[i] = wv[t];
         for (int i = 0; i < 25; i++) in_map[i] = '0;
         in_map[0] = dx[t];
         model();
         run(hl[t], lat, pulses);
         ntotal++;
         if (lat != 4) $display("FAIL imp%0d_lat: got %0d want 4", t, lat);
         else npass++;
         ntotal++;
         if (pulses != 1) $display("FAIL imp%0d_pulses: got %0d want 1", t, pulses);
         else npass++;
         ntotal++;
         if (out_map[0] !== 32'(ex[t])) begin
            $display("FAIL imp%0d_out0: got %0d want %0d", t, out_map[0], ex[t]);
         end else npass++;
         for (int i = 0; i < 9; i++) begin
            ntotal++;
            if (out_map[i] !== exp_map[i]) begin
               $display("FAIL imp%0d_out[%0d]: got %0d want %0d",
                  t, i, out_map[i], exp_map[i]);
            end else npass++;
         end
      end
   endtask

   task automatic test_zero_weights();
      int lat, pulses;
      for (int i = 0; i < 36; i++) wts[i] = '0;
      for (int i = 0; i < 25; i++)
         in_map[i] = (i % 2 == 0) ? 100 * (i + 1) : -100 * (i + 1);
      run(1, lat, pulses);
      ntotal++;
      if (pulses != 1) $display("FAIL zero_pulses: got %0d want 1", pulses);
      else npass++;
      for (int i = 0; i < 9; i++) begin
         ntotal++;
         if (out_map[i] !== 32'sd0) begin
            $display("FAIL zero_out[%0d]: got %0d want 0", i, out_map[i]);
         end else npass++;
      end
   endtask

   task automatic test_random();
      int lat, pulses;
      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 25; i++)
            in_map[i] = int'($urandom_range(8192)) - 4096;
         for (int i = 0; i < 36; i++)
            wts[i] = int'($urandom_range(131072)) - 65536;
         model();
         run(1 + int'($urandom_range(5)), lat, pulses);
         ntotal++;
         if (lat != 4 || pulses != 1) begin
            $display("FAIL rnd%0d_handshake: got lat %0d pulses %0d want 4 1",
               t, lat, pulses);
         end else npass++;
         for (int i = 0; i < 9; i++) begin
            ntotal++;
            if (out_map[i] !== exp_map[i]) begin
               $display("FAIL rnd%0d_out[%0d]: got %0d want %0d",
                  t, i, out_map[i], exp_map[i]);
            end else npass++;
         end
      end
   endtask

   task automatic test_abort();
      int pulses = 0;
      for (int i = 0; i < 25; i++) in_map[i] = i + 1;
      for (int i = 0; i < 36; i++) wts[i] = 256;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (dv) pulses++;
         tick();
      end
      ntotal++;
      if (pulses != 0) $display("FAIL abort_dv: got %0d want 0", pulses);
      else npass++;
      for (int i = 0; i < 9; i++) begin
         ntotal++;
         if (out_map[i] !== 32'sd0) begin
            $display("FAIL abort_out[%0d]: got %0d want 0", i, out_map[i]);
         end else npass++;
      end
   endtask

   task automatic test_back_to_back();
      logic signed [31:0] exp_a [9];
      int lat = -1;
      int pulses = 0;
      for (int i = 0; i < 25; i++)
         in_map[i] = int'($urandom_range(2000)) - 1000;
      for (int i = 0; i < 36; i++)
         wts[i] = int'($urandom_range(4096)) - 2048;
      model();
      exp_a = exp_map;
      start = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         tick();
         if (c == 1) begin
            start = 1'b0;
            for (int i = 0; i < 25; i++)
               in_map[i] = int'($urandom_range(2000)) - 1000;
            for (int i = 0; i < 36; i++)
               wts[i] = int'($urandom_range(4096)) - 2048;
         end
         if (c == 2) start = 1'b1;
         if (c == 3) start = 1'b0;
         if (dv) begin
            pulses++;
            if (lat < 0) lat = c - 1;
         end
      end
      ntotal++;
      if (lat != 4 || pulses != 1) begin
         $display("FAIL busy_handshake: got lat %0d pulses %0d want 4 1",
            lat, pulses);
      end else npass++;
      for (int i = 0; i < 9; i++) begin
         ntotal++;
         if (out_map[i] !== exp_a[i]) begin
            $display("FAIL busy_out[%0d]: got %0d want %0d",
               i, out_map[i], exp_a[i]);
         end else npass++;
      end
      model();
      run(1, lat, pulses);
      ntotal++;
      if (lat != 4 || pulses != 1) begin
         $display("FAIL next_handshake: got lat %0d pulses %0d want 4 1",
            lat, pulses);
      end else npass++;
      for (int i = 0; i < 9; i++) begin
         ntotal++;
         if (out_map[i] !== exp_map[i]) begin
            $display("FAIL next_out[%0d]: got %0d want %0d",
               i, out_map[i], exp_map[i]);
         end else npass++;
      end
   endtask

   initial begin
      test_reset();
      test_impulse();
      test_zero_weights();
      test_random();
      test_abort();
      test_back_to_back();
      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
